pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage pipeline (F, D, E, M, W).
- Sequences the pipeline registers, including the M->W writeback register, with per-stage stall and flush strobes.
- Resolves register-data hazards with forwarding selects and load-use stalls.
- Freezes the pipeline while the data memory is busy, using a wait-state FSM with a timeout.

Parameters:
MEM_TIMEOUT, 16, max WAIT cycles before forced release; must be >=2.
CNT_W, 32, width of the perf counters (used only when STALL_PERF_EN is defined).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
D_rs1, D_rs2  in  5  source regs of the instruction in D
E_rs1, E_rs2  in  5  source regs of the instruction in E
E_rd  in  5  dest reg in E
E_is_load  in  1  E holds a load
E_branch_taken  in  1  branch/jump resolved taken in E
M_rd  in  5  dest reg in M
M_reg_we  in  1  M writes the regfile
M_is_load  in  1  M holds a load
M_mem_req  in  1  M accesses data memory this cycle
dmem_ready  in  1  data memory completes the access this cycle
W_rd  in  5  dest reg in W
W_reg_we  in  1  W writes the regfile
stall_F, stall_D, stall_E, stall_M  out  1  hold the stage register
flush_D, flush_E, flush_W  out  1  load a bubble (all-zero) into the stage register
fwd_rs1_sel, fwd_rs2_sel  out  2  E operand source: 00 regfile, 01 M_alu_out, 10 W writeback data
mem_wait  out  1  FSM in WAIT
mem_err  out  1  sticky timeout flag
load_use_cnt, mem_wait_cnt, flush_cnt  out  CNT_W  perf counters

Behaviour:
Reset (async, rst=1):
- FSM -> IDLE; timeout counter -> 0; mem_err -> 0; perf counters -> 0.
- All stall_*, flush_*, mem_wait forced 0; fwd_*_sel forced 00.

Forwarding (combinational, rs1 and rs2 resolved independently):
- 01 if M_reg_we && !M_is_load && M_rd!=0 && M_rd==E_rsX.
- Else 10 if W_reg_we && W_rd!=0 && W_rd==E_rsX.
- Else 00.
- M match has priority over W match.

FSM states:
- IDLE:
  - If M_mem_req && !dmem_ready -> WAIT next cycle; mem_stall is asserted in this same cycle.
  - M_mem_req && dmem_ready -> stay IDLE, no stall.
- WAIT:
  - mem_wait=1; timeout counter increments each cycle.
  - dmem_ready=1 -> IDLE. Stall released in that same cycle, so M advances.
  - Counter reaches MEM_TIMEOUT-1 without ready -> set mem_err, -> IDLE, release the stall that cycle.
  - The counter clears on entering IDLE.

mem_stall (= (IDLE && M_mem_req && !dmem_ready) || (WAIT && !dmem_ready && !timeout)):
- stall_F=stall_D=stall_E=stall_M=1, flush_W=1. W receives a bubble, so writeback is never repeated.
- All other hazard actions are suppressed.

Load-use (only when !mem_stall and !E_branch_taken):
- Condition: E_is_load && E_rd!=0 && (E_rd==D_rs1 || E_rd==D_rs2).
- Action: stall_F=stall_D=1, flush_E=1 for exactly one cycle.
- Next cycle the load is in M; forwarding from M is blocked and data is taken from W (sel 10).

Branch taken (when !mem_stall):
- flush_D=1 and flush_E=1; no stalls.
- Wins over load-use. Both can only be true from malformed decode.

Priority: mem_stall > branch > load-use > none.

Stall vs flush on the same stage: flush wins.

mem_err clears only on rst.

Optional Feature:
STALL_PERF_EN:
- Defined: the three counters increment by 1 per cycle of, respectively:
  - load-use stall;
  - mem_stall;
  - branch flush.
- Counters saturate at all-ones and reset to 0.
- Undefined: the counter ports remain and are tied to 0; no counter flops are synthesised.

Test Plan:
- Load-use: E_is_load=1, E_rd=5, D_rs2=5 -> one cycle of stall_F=stall_D=flush_E=1. Next cycle (load in M, M_is_load=1, W_rd=5 later) fwd_rs2_sel=10 once W_rd=5, W_reg_we=1.
- Forward priority: M_rd=W_rd=E_rs1=7, both we=1, M_is_load=0 -> fwd_rs1_sel=01. With E_rs1=0 and M_rd=0 -> 00.
- Mem wait: M_mem_req=1, dmem_ready low 3 cycles then high -> stall_F..M and flush_W high for 3 cycles, mem_wait high for 2 of them, release on the ready cycle; mem_err=0.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> stall for 4 cycles, then release; mem_err=1 and remains set until rst.
- Branch during mem stall: E_branch_taken=1 while dmem_ready=0 -> flush_D/E=0 until ready. On the ready cycle flush_D=flush_E=1.
- Async reset mid-WAIT: assert rst between edges -> mem_wait, stalls, and flushes drop immediately; counters=0 (STALL_PERF_EN defined).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward controller for the F-D-E-M-W pipeline.
// Covers forwarding selects, load-use stalls, branch flushes, and a
// data-memory wait-state FSM with a timeout.
// Optional feature macro: STALL_PERF_EN enables the saturating perf counters.
// When the macro is not defined, the counter ports are tied to zero.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic [4:0]       E_rs1,
    input  logic [4:0]       E_rs2,
    input  logic [4:0]       E_rd,
    input  logic             E_is_load,
    input  logic             E_branch_taken,
    input  logic [4:0]       M_rd,
    input  logic             M_reg_we,
    input  logic             M_is_load,
    input  logic             M_mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       W_rd,
    input  logic             W_reg_we,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             mem_wait,
    output logic             mem_err,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int unsigned TW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [TW-1:0] tcnt;
    logic          mem_err_q;
    logic          timeout;
    logic          mem_stall;
    logic          branch_flush;
    logic          load_use;

    // Operand source for one E-stage register; a load in M has no data yet.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (M_reg_we && !M_is_load && (M_rd != 5'd0) && (M_rd == rs))
            return 2'b01;
        else if (W_reg_we && (W_rd != 5'd0) && (W_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hazard classification in priority order: mem_stall > branch > load-use.
    always_comb begin
        timeout      = (state == WAIT) && (tcnt == TMAX) && !dmem_ready;
        mem_stall    = ((state == IDLE) && M_mem_req && !dmem_ready) ||
                       ((state == WAIT) && !dmem_ready && !timeout);
        branch_flush = !mem_stall && E_branch_taken;
        load_use     = !mem_stall && !E_branch_taken && E_is_load &&
                       (E_rd != 5'd0) && ((E_rd == D_rs1) || (E_rd == D_rs2));
    end

    // Wait-state FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (M_mem_req && !dmem_ready) state_nxt = WAIT;
            WAIT:    if (dmem_ready || timeout)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, timeout counter (cleared whenever not staying in WAIT), sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == WAIT) && (state_nxt == WAIT))
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
            if (timeout)
                mem_err_q <= 1'b1;
        end
    end

    // Output strobes; reset forces them low immediately, and flush beats stall.
    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        stall_M     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_W     = 1'b0;
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        mem_wait    = 1'b0;
        if (!rst) begin
            flush_D     = branch_flush;
            flush_E     = branch_flush || load_use;
            flush_W     = mem_stall;
            stall_F     = mem_stall || load_use;
            stall_D     = (mem_stall || load_use) && !flush_D;
            stall_E     = mem_stall && !flush_E;
            stall_M     = mem_stall;
            fwd_rs1_sel = fwd_sel(E_rs1);
            fwd_rs2_sel = fwd_sel(E_rs2);
            mem_wait    = (state == WAIT);
        end
    end

    assign mem_err = mem_err_q;

`ifdef STALL_PERF_EN
    // Saturating perf counters for effective hazard actions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_use_cnt <= '0;
            mem_wait_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (load_use && (load_use_cnt != '1))
                load_use_cnt <= load_use_cnt + 1'b1;
            if (mem_stall && (mem_wait_cnt != '1))
                mem_wait_cnt <= mem_wait_cnt + 1'b1;
            if (branch_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign load_use_cnt = '0;
    assign mem_wait_cnt = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4). The driver sets inputs
// and queues the hand-computed output vector; the monitor compares at negedge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] D_rs1, D_rs2, E_rs1, E_rs2, E_rd, M_rd, W_rd;
    logic E_is_load, E_branch_taken, M_reg_we, M_is_load, M_mem_req, dmem_ready, W_reg_we;
    logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic mem_wait, mem_err;
    logic [CW-1:0] load_use_cnt, mem_wait_cnt, flush_cnt;

    typedef struct {
        string       name;
        logic [12:0] vec;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .E_rs1(E_rs1), .E_rs2(E_rs2), .E_rd(E_rd),
        .E_is_load(E_is_load), .E_branch_taken(E_branch_taken),
        .M_rd(M_rd), .M_reg_we(M_reg_we), .M_is_load(M_is_load),
        .M_mem_req(M_mem_req), .dmem_ready(dmem_ready),
        .W_rd(W_rd), .W_reg_we(W_reg_we),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .mem_wait(mem_wait), .mem_err(mem_err),
        .load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: compare one queued expectation per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [12:0] got;
            e   = sb.pop_front();
            got = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                   fwd_rs1_sel, fwd_rs2_sel, mem_wait, mem_err};
            tests++;
            if (got !== e.vec) begin
                fails++;
                $display("FAIL %s: got stall=%b flush=%b fwd1=%b fwd2=%b wait=%b err=%b, expected stall=%b flush=%b fwd1=%b fwd2=%b wait=%b err=%b",
                         e.name, got[12:9], got[8:6], got[5:4], got[3:2], got[1], got[0],
                         e.vec[12:9], e.vec[8:6], e.vec[5:4], e.vec[3:2], e.vec[1], e.vec[0]);
            end
        end
    end

    task automatic expect_out(input string n, input logic [3:0] st, input logic [2:0] fl,
                              input logic [1:0] f1, input logic [1:0] f2,
                              input logic mw, input logic me);
        exp_t e;
        e.name = n;
        e.vec  = {st, fl, f1, f2, mw, me};
        sb.push_back(e);
    endtask

    task automatic chk_cnt(input string n, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        D_rs1 = 0; D_rs2 = 0; E_rs1 = 0; E_rs2 = 0; E_rd = 0; M_rd = 0; W_rd = 0;
        E_is_load = 0; E_branch_taken = 0; M_reg_we = 0; M_is_load = 0;
        M_mem_req = 0; dmem_ready = 0; W_reg_we = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        M_mem_req = 1'b1;  // outputs must stay low under reset even with a request
        #1;
        expect_out("reset", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_in();
        #1 chk_cnt("reset_lu_cnt", load_use_cnt, 0);

        // Load-use on rs2, then forwarding around the load.
        tick(); E_is_load = 1; E_rd = 5; D_rs2 = 5;
        expect_out("load_use", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); clear_in(); M_rd = 5; M_reg_we = 1; M_is_load = 1; E_rs2 = 5;
        expect_out("lu_m_blocked", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); clear_in(); W_rd = 5; W_reg_we = 1; E_rs2 = 5;
        expect_out("lu_fwd_w", 4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0);

        // Forwarding priority and register zero.
        tick(); clear_in(); M_rd = 7; W_rd = 7; M_reg_we = 1; W_reg_we = 1; E_rs1 = 7;
        expect_out("fwd_m_prio", 4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0);
        tick(); E_rs1 = 0; E_rs2 = 7; M_rd = 0;
        expect_out("fwd_zero", 4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0);
        tick(); E_rs1 = 7; E_rs2 = 3; M_rd = 3; W_rd = 7;
        expect_out("fwd_split", 4'b0000, 3'b000, 2'b10, 2'b01, 1'b0, 1'b0);
        tick(); M_reg_we = 0; W_reg_we = 0;
        expect_out("fwd_no_we", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

        // Branch flush, and branch beating load-use.
        tick(); clear_in(); E_branch_taken = 1;
        expect_out("branch", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); E_is_load = 1; E_rd = 5; D_rs1 = 5;
        expect_out("branch_vs_lu", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);

        // Memory wait: ready low for 3 cycles, load-use suppressed meanwhile.
        tick(); clear_in(); M_mem_req = 1; E_is_load = 1; E_rd = 5; D_rs1 = 5;
        expect_out("mw_enter", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); clear_in(); M_mem_req = 1;
        expect_out("mw_wait1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        expect_out("mw_wait2", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        tick(); dmem_ready = 1;
        expect_out("mw_ready", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        tick(); clear_in();
        expect_out("mw_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); M_mem_req = 1; dmem_ready = 1;
        expect_out("mem_hit", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

        // Branch held during a memory stall only flushes on the ready cycle.
        tick(); clear_in(); M_mem_req = 1; E_branch_taken = 1;
        expect_out("br_mw_enter", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        expect_out("br_mw_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        tick(); dmem_ready = 1;
        expect_out("br_mw_ready", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b1, 1'b0);
        tick(); clear_in();
        expect_out("br_mw_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

        // Timeout with MEM_TIMEOUT=4: four stall cycles, release, sticky error.
        tick(); M_mem_req = 1;
        expect_out("to_enter", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        expect_out("to_wait0", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        expect_out("to_wait1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        expect_out("to_wait2", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        expect_out("to_release", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        tick(); clear_in();
        expect_out("to_err_set", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        tick(); E_branch_taken = 1;
        expect_out("to_err_sticky", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b1);
        tick(); clear_in();
        expect_out("idle_err", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        #1;
`ifdef STALL_PERF_EN
        chk_cnt("load_use_cnt", load_use_cnt, 1);
        chk_cnt("mem_wait_cnt", mem_wait_cnt, 9);
        chk_cnt("flush_cnt", flush_cnt, 4);
`else
        chk_cnt("load_use_cnt_off", load_use_cnt, 0);
        chk_cnt("mem_wait_cnt_off", mem_wait_cnt, 0);
        chk_cnt("flush_cnt_off", flush_cnt, 0);
`endif

        // Asynchronous reset in the middle of WAIT.
        tick(); M_mem_req = 1;
        expect_out("rw_enter", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1);
        tick();
        expect_out("rw_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b1);
        tick(); #1 rst = 1'b1;
        expect_out("rw_async_rst", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        #1;
        chk_cnt("rw_lu_cnt", load_use_cnt, 0);
        chk_cnt("rw_mw_cnt", mem_wait_cnt, 0);
        chk_cnt("rw_fl_cnt", flush_cnt, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_in();
        tick();
        expect_out("rw_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
